rob_commit: RTL

- In-order reorder buffer and commit stage of the OOO core.
- Accepts instructions in program order from dispatch and collects out-of-order writeback results.
- Retires at most one instruction per cycle from the head.
- Emits the commit strobe, committed PC and architectural-register write consumed by the architectural RF and by the OOO-vs-ISA correctness checker (veri_commit / veri_pc_last source).

---
 rtl/rob_commit_pkg.sv | 18 +
 rtl/rob_ptr.sv | 24 ++
 rtl/rob_commit.sv | 113 +++++++++++
 3 files changed

// File: rtl/rob_commit_pkg.sv
// Shared ROB geometry and entry layout for the commit stage.
// Sized alongside the ISA header: PC_W/REG_W/DATA_W must track it.
package rob_commit_pkg;
    localparam int ROB_SIZE  = 4;
    localparam int ROB_IDX_W = 2;
    localparam int PC_W      = 4;
    localparam int REG_W     = 2;
    localparam int DATA_W    = 8;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [PC_W-1:0]   pc;
        logic [REG_W-1:0]  rd;
        logic              wen;
        logic [DATA_W-1:0] data;
    } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit ROB pointer: index in the low bits, lap parity in the MSB.
// Compares against a peer pointer: same = empty-style, opposite = full-style.
module rob_ptr
    import rob_commit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic [ROB_IDX_W:0]   peer,
    output logic [ROB_IDX_W:0]   ptr,
    output logic                 same,
    output logic                 opposite
);
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + (ROB_IDX_W+1)'(1);
    end

    assign same     = (ptr == peer);
    assign opposite = (ptr[ROB_IDX_W-1:0] == peer[ROB_IDX_W-1:0]) &&
                      (ptr[ROB_IDX_W] != peer[ROB_IDX_W]);
endmodule

// File: rtl/rob_commit.sv
// In-order ROB + commit stage; ROB_ALLOC_ON_COMMIT_EN lets a full ROB accept into the retiring slot.
// Latency: writeback -> commit_valid is 2 cycles minimum; commit outputs are registered.
// Backpressure: alloc_ready drops when full; writeback and commit are never stalled.
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    input  logic [PC_W-1:0]      alloc_pc,
    input  logic [REG_W-1:0]     alloc_rd,
    input  logic                 alloc_wen,
    output logic [ROB_IDX_W-1:0] alloc_tag,
    input  logic                 wb_valid,
    input  logic [ROB_IDX_W-1:0] wb_tag,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 commit_valid,
    output logic [PC_W-1:0]      commit_pc,
    output logic [REG_W-1:0]     commit_rd,
    output logic                 commit_wen,
    output logic [DATA_W-1:0]    commit_data,
    output logic                 empty,
    output logic                 full
);
    rob_entry_t rob [ROB_SIZE];

    logic [ROB_IDX_W:0]   head_ptr, tail_ptr;
    logic [ROB_IDX_W-1:0] head_idx, tail_idx;
    logic head_same, head_opp, tail_same, tail_opp;
    logic commit_fire, alloc_fire;

    rob_ptr u_head (
        .clk      (clk),
        .rst      (rst),
        .inc      (commit_fire),
        .peer     (tail_ptr),
        .ptr      (head_ptr),
        .same     (head_same),
        .opposite (head_opp)
    );

    rob_ptr u_tail (
        .clk      (clk),
        .rst      (rst),
        .inc      (alloc_fire),
        .peer     (head_ptr),
        .ptr      (tail_ptr),
        .same     (tail_same),
        .opposite (tail_opp)
    );

    assign head_idx = head_ptr[ROB_IDX_W-1:0];
    assign tail_idx = tail_ptr[ROB_IDX_W-1:0];
    assign empty    = head_same && tail_same;
    assign full     = head_opp && tail_opp;
    assign alloc_tag = tail_idx;

    // Retire decision uses registered entry state only, so a same-cycle writeback waits a cycle.
    assign commit_fire = rob[head_idx].valid && rob[head_idx].done;

`ifdef ROB_ALLOC_ON_COMMIT_EN
    assign alloc_ready = !full || commit_fire;
`else
    assign alloc_ready = !full;
`endif

    assign alloc_fire = alloc_valid && alloc_ready;

    // Later assignments win: commit clear, then writeback, then alloc into a freed head slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++)
                rob[i] <= '0;
        end else begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (commit_fire && head_idx == ROB_IDX_W'(i)) begin
                    rob[i].valid <= 1'b0;
                    rob[i].done  <= 1'b0;
                end
                if (wb_valid && wb_tag == ROB_IDX_W'(i) && rob[i].valid && !rob[i].done) begin
                    rob[i].done <= 1'b1;
                    rob[i].data <= wb_data;
                end
                if (alloc_fire && tail_idx == ROB_IDX_W'(i)) begin
                    rob[i].valid <= 1'b1;
                    rob[i].done  <= 1'b0;
                    rob[i].pc    <= alloc_pc;
                    rob[i].rd    <= alloc_rd;
                    rob[i].wen   <= alloc_wen;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_wen   <= 1'b0;
            commit_pc    <= '0;
            commit_rd    <= '0;
            commit_data  <= '0;
        end else begin
            commit_valid <= commit_fire;
            commit_wen   <= commit_fire && rob[head_idx].wen;
            if (commit_fire) begin
                commit_pc   <= rob[head_idx].pc;
                commit_rd   <= rob[head_idx].rd;
                commit_data <= rob[head_idx].data;
            end
        end
    end
endmodule
